// File: rtl/pwm_multi_timer_pkg.sv
// Shared types and default sizing for the multi-channel PWM timer.
// Imported by pwm_multi_timer; the optional IRQ feature is PWM_MULTI_TIMER_IRQ_EN.
package pwm_multi_timer_pkg;

    localparam int DEFAULT_WORD_WIDTH = 32;
    localparam int DEFAULT_N_CH       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pwm_compare_ch.sv
// One PWM channel: duty shadow register plus a registered compare against the
// counter value that will be presented on the next cycle.
module pwm_compare_ch #(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [WORD_WIDTH-1:0] duty,
    input  logic [WORD_WIDTH-1:0] count_next,
    input  logic                  run_next,
    output logic                  pwm
);

    logic [WORD_WIDTH-1:0] duty_sh_reg;
    logic [WORD_WIDTH-1:0] duty_sh_next;
    logic                  pwm_reg;
    logic                  pwm_next;

    // Compare uses next-cycle count and shadow so pwm lines up with count.
    always_comb begin
        duty_sh_next = load ? duty : duty_sh_reg;
        pwm_next     = run_next && (count_next < duty_sh_next);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_sh_reg <= '0;
            pwm_reg     <= 1'b0;
        end else begin
            duty_sh_reg <= duty_sh_next;
            pwm_reg     <= pwm_next;
        end
    end

    assign pwm = pwm_reg;

endmodule

// File: rtl/pwm_multi_timer.sv
// Multi-channel PWM timer: shared period counter with IDLE/RUN/DONE control and
// per-channel compare. Optional sticky wrap interrupt under PWM_MULTI_TIMER_IRQ_EN.
module pwm_multi_timer
    import pwm_multi_timer_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
    parameter int N_CH       = DEFAULT_N_CH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       restart,
    input  logic                       oneshot,
    input  logic [WORD_WIDTH-1:0]      period,
    input  logic [N_CH*WORD_WIDTH-1:0] duty,
`ifdef PWM_MULTI_TIMER_IRQ_EN
    input  logic                       irq_clr,
    output logic                       irq,
`endif
    output logic [WORD_WIDTH-1:0]      count,
    output logic [N_CH-1:0]            pwm_out,
    output logic                       wrap,
    output logic                       done
);

    localparam logic [WORD_WIDTH-1:0] ONE_W = {{(WORD_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_reg;
    state_t                state_next;
    logic [WORD_WIDTH-1:0] count_reg;
    logic [WORD_WIDTH-1:0] count_next;
    logic [WORD_WIDTH-1:0] period_sh_reg;
    logic [WORD_WIDTH-1:0] period_sh_next;
    logic                  load;
    logic                  at_end;
    logic                  run_next;

    // period_sh is never 0 in RUN, so the subtraction cannot underflow there.
    assign at_end   = (state_reg == RUN) && (count_reg == period_sh_reg - ONE_W);
    assign run_next = (state_next == RUN);

    always_comb begin
        state_next = state_reg;
        count_next = '0;
        load       = 1'b0;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (period != '0) begin
                        state_next = RUN;
                        load       = 1'b1;
                    end
                end
                RUN: begin
                    // restart outranks the wrap: it keeps the block running.
                    if (restart || at_end) begin
                        load = 1'b1;
                        if (period == '0) begin
                            state_next = IDLE;
                        end else if (!restart && oneshot) begin
                            state_next = DONE;
                        end
                    end else begin
                        count_next = count_reg + ONE_W;
                    end
                end
                DONE: begin
                    if (restart) begin
                        load       = 1'b1;
                        state_next = (period == '0) ? IDLE : RUN;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
        period_sh_next = load ? period : period_sh_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            period_sh_reg <= '0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            period_sh_reg <= period_sh_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            pwm_compare_ch #(
                .WORD_WIDTH(WORD_WIDTH)
            ) u_ch (
                .clk       (clk),
                .rst       (rst),
                .load      (load),
                .duty      (duty[gi*WORD_WIDTH +: WORD_WIDTH]),
                .count_next(count_next),
                .run_next  (run_next),
                .pwm       (pwm_out[gi])
            );
        end
    endgenerate

`ifdef PWM_MULTI_TIMER_IRQ_EN
    logic irq_reg;
    logic irq_set;

    assign irq_set = at_end || ((state_next == DONE) && (state_reg != DONE));

    // A coincident set beats the clear so no wrap event is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_reg <= 1'b0;
        end else if (irq_set) begin
            irq_reg <= 1'b1;
        end else if (irq_clr) begin
            irq_reg <= 1'b0;
        end
    end

    assign irq = irq_reg;
`endif

    assign count = count_reg;
    assign wrap  = at_end;
    assign done  = (state_reg == DONE);

endmodule

// File: tb/tb_pwm_multi_timer.sv
// Self-checking bench for pwm_multi_timer: directed scenarios plus randomized
// stimulus against a cycle-level behavioural model.
module tb_pwm_multi_timer;

    localparam int W  = 16;
    localparam int NC = 4;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          restart = 1'b0;
    logic          oneshot = 1'b0;
    logic [W-1:0]  period = '0;
    logic [NC*W-1:0] duty = '0;
    logic [W-1:0]  count;
    logic [NC-1:0] pwm_out;
    logic          wrap;
    logic          done;
`ifdef PWM_MULTI_TIMER_IRQ_EN
    logic          irq_clr = 1'b0;
    logic          irq;
`endif

    int checks = 0;
    int errors = 0;

    // behavioural model state
    int m_state = M_IDLE;
    int m_cnt = 0;
    int m_per = 0;
    int m_duty[NC];
    bit m_irq = 1'b0;

    pwm_multi_timer #(.WORD_WIDTH(W), .N_CH(NC)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .restart(restart),
        .oneshot(oneshot),
        .period (period),
        .duty   (duty),
`ifdef PWM_MULTI_TIMER_IRQ_EN
        .irq_clr(irq_clr),
        .irq    (irq),
`endif
        .count  (count),
        .pwm_out(pwm_out),
        .wrap   (wrap),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic set_duty(input int d0, input int d1, input int d2, input int d3);
        duty = {d3[W-1:0], d2[W-1:0], d1[W-1:0], d0[W-1:0]};
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_cnt   = 0;
        m_per   = 0;
        for (int i = 0; i < NC; i++) m_duty[i] = 0;
        m_irq = 1'b0;
    endtask

    task automatic model_load();
        m_per = int'(period);
        for (int i = 0; i < NC; i++) m_duty[i] = int'(duty[i*W +: W]);
    endtask

    // One clock edge of the specified behaviour, using the inputs present at the edge.
    task automatic model_clock();
        bit last_step;
        bit irq_ev;
        bit clr;
        last_step = (m_state == M_RUN) && (m_cnt == m_per - 1);
        irq_ev = last_step;
        clr = 1'b0;
`ifdef PWM_MULTI_TIMER_IRQ_EN
        clr = irq_clr;
`endif
        if (!enable) begin
            m_state = M_IDLE;
            m_cnt = 0;
        end else if (m_state == M_IDLE) begin
            if (period != 0) begin
                model_load();
                m_state = M_RUN;
                m_cnt = 0;
            end
        end else if (m_state == M_RUN) begin
            if (restart || last_step) begin
                model_load();
                m_cnt = 0;
                if (period == 0) m_state = M_IDLE;
                else if (!restart && oneshot) m_state = M_DONE;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end else begin
            m_cnt = 0;
            if (restart) begin
                model_load();
                m_state = (period == 0) ? M_IDLE : M_RUN;
            end
        end
        if (irq_ev) m_irq = 1'b1;
        else if (clr) m_irq = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (count !== '0 || pwm_out !== '0 || wrap !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: count=%0d pwm=%b wrap=%b done=%b, required all 0", count, pwm_out, wrap, done);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step();
        checks++;
        if (count !== '0 || pwm_out !== '0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: count=%0d pwm=%b done=%b, required 0", count, pwm_out, done);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        logic [NC-1:0] exp_pwm;
        period = 5; set_duty(0, 2, 5, 7); oneshot = 0; enable = 1;
        for (int k = 0; k < 15; k++) begin
            step();
            exp_pwm = {1'b1, 1'b1, (k % 5) < 2, 1'b0};
            checks++;
            if (count !== W'(k % 5) || wrap !== ((k % 5) == 4) || pwm_out !== exp_pwm || done !== 1'b0) begin
                errors++;
                $display("FAIL basic k=%0d: count=%0d wrap=%b pwm=%b, required count=%0d wrap=%b pwm=%b",
                         k, count, wrap, pwm_out, k % 5, (k % 5) == 4, exp_pwm);
            end
        end
        $display("test_basic done");
    endtask

    task automatic test_oneshot();
        logic [NC-1:0] exp_pwm;
        enable = 0; step();
        period = 3; set_duty(0, 1, 2, 3); oneshot = 1; enable = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            exp_pwm = {1'b1, k < 2, k < 1, 1'b0};
            checks++;
            if (count !== W'(k) || wrap !== (k == 2) || done !== 1'b0 || pwm_out !== exp_pwm) begin
                errors++;
                $display("FAIL oneshot_run k=%0d: count=%0d wrap=%b done=%b pwm=%b, required %0d %b 0 %b",
                         k, count, wrap, done, pwm_out, k, k == 2, exp_pwm);
            end
        end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (done !== 1'b1 || count !== '0 || pwm_out !== '0 || wrap !== 1'b0) begin
                errors++;
                $display("FAIL oneshot_done k=%0d: done=%b count=%0d pwm=%b wrap=%b, required 1 0 0000 0",
                         k, done, count, pwm_out, wrap);
            end
        end
        restart = 1;
        step();
        restart = 0;
        checks++;
        if (done !== 1'b0 || count !== '0 || pwm_out !== 4'b1110) begin
            errors++;
            $display("FAIL oneshot_restart: done=%b count=%0d pwm=%b, required 0 0 1110", done, count, pwm_out);
        end
        step();
        checks++;
        if (count !== W'(1)) begin
            errors++;
            $display("FAIL oneshot_restart_count: count=%0d, required 1", count);
        end
        oneshot = 0;
        $display("test_oneshot done");
    endtask

    task automatic test_shadow();
        int exp_seq[11] = '{3, 4, 5, 6, 7, 0, 1, 2, 3, 0, 1};
        bit hit;
        enable = 0; step();
        period = 8; set_duty(3, 3, 3, 3); oneshot = 0; enable = 1;
        hit = 0;
        for (int t = 0; t < 10 && !hit; t++) begin
            step();
            if (count == W'(2)) hit = 1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL shadow_reach2: count=%0d, required to reach 2 within 10 cycles", count);
        end
        period = 4;
        for (int i = 0; i < 11; i++) begin
            step();
            checks++;
            if (count !== W'(exp_seq[i]) || wrap !== (i == 4 || i == 8) || pwm_out !== {NC{exp_seq[i] < 3}}) begin
                errors++;
                $display("FAIL shadow i=%0d: count=%0d wrap=%b pwm=%b, required count=%0d wrap=%b",
                         i, count, wrap, pwm_out, exp_seq[i], i == 4 || i == 8);
            end
        end
        $display("test_shadow done");
    endtask

    task automatic test_restart_wrap();
        bit hit;
        enable = 0; step();
        period = 4; set_duty(1, 1, 1, 1); enable = 1;
        hit = 0;
        for (int t = 0; t < 10 && !hit; t++) begin
            step();
            if (count == W'(3)) hit = 1;
        end
        checks++;
        if (!hit || wrap !== 1'b1) begin
            errors++;
            $display("FAIL restart_wrap_setup: count=%0d wrap=%b, required 3 1", count, wrap);
        end
        restart = 1; period = 6; set_duty(4, 4, 4, 4);
        for (int k = 0; k < 12; k++) begin
            step();
            if (k == 0) restart = 0;
            checks++;
            if (count !== W'(k % 6) || wrap !== ((k % 6) == 5) || pwm_out !== {NC{(k % 6) < 4}}) begin
                errors++;
                $display("FAIL restart_wrap k=%0d: count=%0d wrap=%b pwm=%b, required count=%0d wrap=%b",
                         k, count, wrap, pwm_out, k % 6, (k % 6) == 5);
            end
        end
        $display("test_restart_wrap done");
    endtask

    task automatic test_reset_mid();
        bit hit;
        enable = 0; step();
        period = 6; set_duty(1, 2, 3, 4); enable = 1;
        hit = 0;
        for (int t = 0; t < 10 && !hit; t++) begin
            step();
            if (count == W'(3)) hit = 1;
        end
        #2;
        rst = 1;
        model_reset();
        #1;
        checks++;
        if (!hit || count !== '0 || pwm_out !== '0 || wrap !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: reached3=%0d count=%0d pwm=%b wrap=%b done=%b, required all 0",
                     hit, count, pwm_out, wrap, done);
        end
        @(negedge clk);
        rst = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if (count !== W'(k % 6)) begin
                errors++;
                $display("FAIL reset_mid_resume k=%0d: count=%0d, required %0d", k, count, k % 6);
            end
        end
        $display("test_reset_mid done");
    endtask

`ifdef PWM_MULTI_TIMER_IRQ_EN
    task automatic test_irq();
        bit hit;
        enable = 0; irq_clr = 1; step();
        irq_clr = 0;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear: irq=%b, required 0", irq);
        end
        period = 3; oneshot = 0; enable = 1;
        hit = 0;
        for (int t = 0; t < 10 && !hit; t++) begin
            step();
            if (wrap === 1'b1) hit = 1;
        end
        irq_clr = 1;
        step();
        checks++;
        if (!hit || irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_set_wins: irq=%b, required 1", irq);
        end
        step();
        irq_clr = 0;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_clr_later: irq=%b, required 0", irq);
        end
        $display("test_irq done");
    endtask
`endif

    task automatic test_random();
        logic [NC-1:0] exp_pwm;
        int bad = 0;
        enable = 0; step();
        for (int n = 0; n < 400; n++) begin
            enable  = ($urandom_range(0, 19) != 0);
            restart = ($urandom_range(0, 19) == 0);
            oneshot = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 9) == 0) period = W'($urandom_range(0, 9));
            if ($urandom_range(0, 7) == 0)
                set_duty($urandom_range(0, 11), $urandom_range(0, 11), $urandom_range(0, 11), $urandom_range(0, 11));
`ifdef PWM_MULTI_TIMER_IRQ_EN
            irq_clr = ($urandom_range(0, 3) == 0);
`endif
            step();
            for (int i = 0; i < NC; i++) exp_pwm[i] = (m_state == M_RUN) && (m_cnt < m_duty[i]);
            checks++;
            if (count !== W'(m_cnt) || pwm_out !== exp_pwm ||
                wrap !== ((m_state == M_RUN) && (m_cnt == m_per - 1)) || done !== (m_state == M_DONE)) begin
                errors++;
                bad++;
                if (bad < 10)
                    $display("FAIL random n=%0d: count=%0d pwm=%b wrap=%b done=%b, required count=%0d pwm=%b state=%0d per=%0d",
                             n, count, pwm_out, wrap, done, m_cnt, exp_pwm, m_state, m_per);
            end
`ifdef PWM_MULTI_TIMER_IRQ_EN
            checks++;
            if (irq !== m_irq) begin
                errors++;
                $display("FAIL random_irq n=%0d: irq=%b, required %b", n, irq, m_irq);
            end
`endif
        end
        restart = 0;
        $display("test_random done");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_oneshot();
        test_shadow();
        test_restart_wrap();
        test_reset_mid();
`ifdef PWM_MULTI_TIMER_IRQ_EN
        test_irq();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
